stepdir_decoder: RTL and testbench

- Receiver end of the step/dir interface: decodes external step and dir pins into a signed position count and a step-period measurement.
- Sits behind input pins driven by an external step generator (encoder emulation, or feedback of our own step/dir outputs) and feeds the host register map.
- Inputs are asynchronous to clk, so they are synchronised (and optionally deglitched) before decoding.

---
 rtl/stepdir_decoder.sv | 151 +++++++++++++++
 tb/tb_stepdir_decoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/stepdir_decoder.sv
// stepdir_decoder: step/dir receiver.
// - Synchronises the asynchronous step/dir pins.
// - Counts a signed position from the accepted step edges.
// - Measures the clocks between the last two accepted steps.
// Optional input deglitch filter: define STEPDIR_DECODER_FILTER_EN.
module stepdir_decoder #(
  parameter int unsigned TIMEOUT    = 5000000,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        pos_clear,
  input  logic        step,
  input  logic        dir,
  output logic [31:0] position,
  output logic [31:0] period,
  output logic        moving,
  output logic        dir_last,
  output logic        step_strobe
);

  localparam logic [31:0] TO = 32'(TIMEOUT);

  typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

  // bit 0 = step, bit 1 = dir; both share one pipeline so their relative timing is kept
  logic [1:0] sync1, sync2, cond;
  logic       step_d;
  logic       rise, accept;

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt, period_nxt;

  // two-flop synchroniser for the asynchronous pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {dir, step};
      sync2 <= sync1;
    end
  end

`ifdef STEPDIR_DECODER_FILTER_EN
  logic [1:0][7:0] flt_cnt;
  logic [1:0]      flt_q;

  // per-signal deglitch: adopt the new level only after FILTER_LEN consecutive differing clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_cnt <= '0;
      flt_q   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == flt_q[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == 8'(FILTER_LEN - 1)) begin
          flt_q[i]   <= sync2[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign cond = flt_q;
`else
  assign cond = sync2;
`endif

  // The edge detector keeps tracking while disabled, so a level already high
  // when enable rises is not mistaken for a new step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_d <= 1'b0;
    else        step_d <= cond[0];
  end

  assign rise   = cond[0] & ~step_d;
  assign accept = rise & enable;

  // position accumulator; clear takes priority over a coincident step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         position <= '0;
    else if (pos_clear) position <= '0;
    else if (accept)    position <= cond[1] ? position + 32'd1 : position - 32'd1;
  end

  // per-step side outputs: direction latch and one-cycle strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_last    <= 1'b0;
      step_strobe <= 1'b0;
    end else begin
      step_strobe <= accept;
      if (accept) dir_last <= cond[1];
    end
  end

  // period FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= STOPPED;
      cnt    <= '0;
      period <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      period <= period_nxt;
    end
  end

  // period FSM next state: a step arriving on the timeout cycle wins over the timeout
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    period_nxt = period;
    if (!enable) begin
      state_nxt  = STOPPED;
      cnt_nxt    = '0;
      period_nxt = '0;
    end else begin
      case (state)
        STOPPED: begin
          if (accept) begin
            state_nxt = RUNNING;
            cnt_nxt   = '0;
          end
        end
        RUNNING: begin
          if (accept) begin
            period_nxt = cnt + 32'd1;
            cnt_nxt    = '0;
          end else if (cnt + 32'd1 == TO) begin
            state_nxt  = STOPPED;
            period_nxt = '0;
            cnt_nxt    = TO;
          end else begin
            cnt_nxt = cnt + 32'd1;
          end
        end
        default: state_nxt = STOPPED;
      endcase
    end
  end

  assign moving = (state == RUNNING);

endmodule

// File: tb/tb_stepdir_decoder.sv
// tb_stepdir_decoder: randomized and directed stimulus for stepdir_decoder.
// The reference model works from pin-level step history and step timestamps.
module tb_stepdir_decoder;

  localparam int TMO = 100;

  logic        clk, rst_n, enable, pos_clear, step, dir;
  logic [31:0] position, period;
  logic        moving, dir_last, step_strobe;

  stepdir_decoder #(.TIMEOUT(TMO), .FILTER_LEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pos_clear(pos_clear),
    .step(step), .dir(dir), .position(position), .period(period),
    .moving(moving), .dir_last(dir_last), .step_strobe(step_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int strb_cnt = 0;

  // reference state
  logic [31:0] m_pos, m_per;
  logic        m_mov, m_dlast, m_strb;
  int          now, m_last;
  logic [2:0]  sh, dh;   // pin samples from 1, 2 and 3 clocks ago

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_pos = '0; m_per = '0; m_mov = 1'b0; m_dlast = 1'b0; m_strb = 1'b0;
    sh = '0; dh = '0; m_last = 0;
  endtask

  // a step is seen two clocks after the pin is sampled; it counts where the pin
  // went 0->1 between consecutive samples and enable is high
  task automatic model_edge();
    logic acc, dv;
    acc = sh[1] & ~sh[2] & enable;
    dv  = dh[1];
    m_strb = acc;
    if (pos_clear)  m_pos = '0;
    else if (acc)   m_pos = dv ? m_pos + 32'd1 : m_pos - 32'd1;
    if (acc) m_dlast = dv;
    if (!enable) begin
      m_mov = 1'b0; m_per = '0;
    end else if (acc) begin
      m_per  = m_mov ? 32'(now - m_last) : 32'd0;
      m_mov  = 1'b1;
      m_last = now;
    end else if (m_mov && (now - m_last) >= TMO) begin
      m_mov = 1'b0; m_per = '0;
    end
    sh = {sh[1:0], step};
    dh = {dh[1:0], dir};
  endtask

  task automatic tick();
    @(posedge clk);
    now++;
    if (rst_n) model_edge();
    @(negedge clk);
    if (step_strobe) strb_cnt++;
    chk("pos",   position,             m_pos);
    chk("per",   period,               m_per);
    chk("mov",   32'(moving),          32'(m_mov));
    chk("dlast", 32'(dir_last),        32'(m_dlast));
    chk("strb",  32'(step_strobe),     32'(m_strb));
  endtask

  task automatic pulse(input int hi, input int lo);
    step = 1'b1;
    repeat (hi) tick();
    step = 1'b0;
    repeat (lo) tick();
  endtask

  logic [31:0] snap;
  int hi, lo, r;

  initial begin
    now = 0;
    rst_n = 1'b0; enable = 1'b0; pos_clear = 1'b0; step = 1'b0; dir = 1'b0;
    model_clear();

    // reset and idle
    repeat (5) tick();
    chk("rst_pos", position, 32'd0);
    chk("rst_per", period, 32'd0);
    chk("rst_mov", 32'(moving), 32'd0);
    chk("rst_strb", 32'(step_strobe), 32'd0);
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (100) tick();
    chk("idle_pos", position, 32'd0);
    chk("idle_per", period, 32'd0);

    // counting
    dir = 1'b1; strb_cnt = 0;
    repeat (10) pulse(4, 6);
    chk("cnt_up", position, 32'd10);
    chk("cnt_strb", 32'(strb_cnt), 32'd10);
    chk("cnt_per", period, 32'd10);
    dir = 1'b0;
    repeat (3) pulse(4, 6);
    chk("cnt_dn", position, 32'd7);
    chk("cnt_dlast", 32'(dir_last), 32'd0);

    // period and timeout
    repeat (150) tick();
    chk("stop_mov", 32'(moving), 32'd0);
    dir = 1'b1;
    pulse(4, 16);
    chk("p1_per", period, 32'd0);
    chk("p1_mov", 32'(moving), 32'd1);
    repeat (4) pulse(4, 16);
    chk("p5_per", period, 32'd20);
    repeat (82) tick();
    chk("to99_mov", 32'(moving), 32'd1);
    tick();
    chk("to100_mov", 32'(moving), 32'd0);
    chk("to100_per", period, 32'd0);

    // wrap and clear priority
    force dut.position = 32'h7FFF_FFFF;
    #1;
    release dut.position;
    m_pos = 32'h7FFF_FFFF;
    pulse(2, 4);
    chk("wrap_up", position, 32'h8000_0000);
    dir = 1'b0;
    pulse(2, 4);
    chk("wrap_dn", position, 32'h7FFF_FFFF);
    dir = 1'b1;
    step = 1'b1;
    tick(); tick();
    pos_clear = 1'b1;
    tick();
    pos_clear = 1'b0;
    chk("clr_pos", position, 32'd0);
    chk("clr_strb", 32'(step_strobe), 32'd1);
    step = 1'b0;
    repeat (5) tick();

    // enable low
    snap = m_pos;
    enable = 1'b0;
    repeat (5) pulse(3, 5);
    chk("en_pos", position, snap);
    chk("en_per", period, 32'd0);
    step = 1'b1;
    repeat (3) tick();
    enable = 1'b1;
    repeat (6) tick();
    chk("en_high", position, snap);
    step = 1'b0;
    repeat (4) tick();

    // reset while step is high: the first synchronised rise after release counts
    pos_clear = 1'b1; tick(); pos_clear = 1'b0;
    step = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("mrst_pos", position, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("mrst_one", position, 32'd1);
    step = 1'b0;
    repeat (4) tick();
    pulse(3, 5);
    chk("mrst_two", position, 32'd2);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) enable = 1'b0;
      else if (r <= 4) enable = 1'b1;
      if ($urandom_range(0, 3) == 0) dir = ~dir;
      if (r == 2) begin
        pos_clear = 1'b1; tick(); pos_clear = 1'b0;
      end
      hi = $urandom_range(1, 6);
      if (r >= 8) lo = $urandom_range(98, 101) - hi;
      else        lo = $urandom_range(1, 25);
      pulse(hi, lo);
      if (r == 3) repeat ($urandom_range(90, 130)) tick();
    end
    enable = 1'b1;
    repeat (120) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
